// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo
// Byte FIFO that feeds a USART transmitter. Bytes are written at the tail.
// The head byte is presented continuously on data_out/valid. It is removed
// only when the transmitter signals the end of a frame by raising tx_ready.
// A rising edge of tx_ready is detected after two register stages.
//
// Ports
//   serial_clock   in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   write_data     in   [7:0] byte to enqueue
//   write_strobe   in   enqueue write_data this cycle
//   clear_overflow in   clears the sticky overflow flag
//   full           out  count == DEPTH
//   empty          out  count == 0
//   count          out  [COUNT_WIDTH-1:0] bytes stored, including the head
//   overflow       out  sticky: a write was dropped because the FIFO was full
//   data_out       out  [7:0] head byte, goes to the transmitter's data_in
//   valid          out  head byte present, goes to the transmitter's valid
//   tx_ready       in   transmitter ready, high for one bit period after stop
module usart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   serial_clock,
    input  logic                   reset,
    input  logic [7:0]             write_data,
    input  logic                   write_strobe,
    input  logic                   clear_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow,
    output logic [7:0]             data_out,
    output logic                   valid,
    input  logic                   tx_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]             mem_reg [DEPTH];
    logic [7:0]             head_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   overflow_reg;
    logic                   tx_ready_q1;
    logic                   tx_ready_q2;

    logic                   pop_event;
    logic                   pop_do;
    logic                   write_do;
    logic [PTR_W-1:0]       rd_ptr_next;

    assign full     = (count_reg == COUNT_WIDTH'(DEPTH));
    assign empty    = (count_reg == '0);
    assign valid    = !empty;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign data_out = head_reg;

    // One pulse per tx_ready rising edge. The pulse is seen one edge after
    // the rise, so the pop lands on the second edge after the rise.
    assign pop_event = tx_ready_q1 & !tx_ready_q2;
    assign pop_do    = pop_event && !empty;
    // A full FIFO still takes the write when a pop frees a slot in the same cycle.
    assign write_do  = write_strobe && (!full || pop_do);

    assign rd_ptr_next = pop_do ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    always_ff @(posedge serial_clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            tx_ready_q1  <= 1'b0;
            tx_ready_q2  <= 1'b0;
        end else begin
            tx_ready_q1 <= tx_ready;
            tx_ready_q2 <= tx_ready_q1;
            if (write_do) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + COUNT_WIDTH'(write_do) - COUNT_WIDTH'(pop_do);
            // A dropped write wins over a same-cycle clear.
            if (write_strobe && !write_do) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage and head register have no reset; valid qualifies data_out.
    // The head is a registered read of the next read address. When the byte
    // being written becomes the new head (the FIFO was empty, or one entry is
    // popped while another is written), the write data is forwarded because
    // the array still holds the old contents at that address.
    always_ff @(posedge serial_clock) begin
        if (!reset && write_do) begin
            mem_reg[wr_ptr_reg] <= write_data;
        end
        if (write_do && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= write_data;
        end else begin
            head_reg <= mem_reg[rd_ptr_next];
        end
    end

endmodule

// File: doc/usart_tx_fifo.md
USART_TX_FIFO -- requirements
Module: usart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter COUNT_WIDTH, default 5, width of count; SHALL equal log2(DEPTH)+1.
REQ-003 serial_clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write_data  input  8  byte to enqueue.
REQ-006 write_strobe  input  1  enqueue write_data this cycle.
REQ-007 clear_overflow  input  1  clears the overflow flag.
REQ-008 full  output  1  count == DEPTH.
REQ-009 empty  output  1  count == 0.
REQ-010 count  output  COUNT_WIDTH  number of stored bytes, including the byte currently presented.
REQ-011 overflow  output  1  sticky flag: a write was dropped.
REQ-012 data_out  output  8  head byte, driven to the transmitter's data_in.
REQ-013 valid  output  1  head byte present, driven to the transmitter's valid.
REQ-014 tx_ready  input  1  transmitter's ready; high for one bit-clock period after a stop bit.

Function
REQ-015 valid SHALL equal !empty.
REQ-016 data_out SHALL equal the head entry whenever valid=1, and SHALL be stable until that entry is popped.
REQ-017 tx_ready SHALL be registered twice (tx_ready_q1, tx_ready_q2); a pop event SHALL be tx_ready_q1 & !tx_ready_q2.
REQ-018 Pop timing: the head entry SHALL be removed on the 2nd rising edge after tx_ready rises, and the next byte SHALL be presented at that same edge.
REQ-019 Correct handoff SHALL require clocks_per_bit >= 3 on the transmitter.
REQ-020 A head byte SHALL stay presented through its whole frame; it SHALL be popped only on a pop event, never on acceptance.
REQ-021 A pop event while empty SHALL be ignored: no pointer change, count stays 0.
REQ-022 Write with !full: the byte SHALL be stored at the write pointer, the write pointer SHALL increment, and count SHALL increment.
REQ-023 Write with full, and no pop that cycle: the byte SHALL be dropped, overflow SHALL be set to 1, and count SHALL stay DEPTH.
REQ-024 Simultaneous write and pop with count>0: both SHALL occur, count SHALL be unchanged, and a full FIFO SHALL accept the write.
REQ-025 Write into empty FIFO: valid=1 and data_out=written byte SHALL hold from the next cycle.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 Order SHALL be strict FIFO across pointer wrap.
REQ-028 Overflow SHALL clear only on clear_overflow=1 or reset; a same-cycle dropped write SHALL take priority and leave overflow=1.
REQ-029 The storage array SHALL have no reset requirement; only pointers, count and flags SHALL be reset.

Reset
REQ-030 On reset=1 at a clock edge: pointers=0, count=0, empty=1, full=0, valid=0, overflow=0, tx_ready_q1=tx_ready_q2=0.
REQ-031 Reset SHALL override any write_strobe, pop event or clear_overflow in the same cycle.
REQ-032 Reset mid-frame SHALL discard all entries, including the in-flight byte; a later tx_ready pulse SHALL be ignored as a pop on an empty FIFO.
REQ-033 Post-reset power-up values SHALL match REQ-030.

Verification
REQ-034 Single byte: write 0xA5 into empty FIFO -> next cycle valid=1, data_out=0xA5, count=1; tx_ready pulse -> valid=0 two edges after its rise.
REQ-035 Back-to-back stream through a usart_tx model, clocks_per_bit=4: write 0x55,0x0F,0xF0 -> tx_pin frames the three bytes in order, no gap beyond one idle bit, count returns to 0.
REQ-036 Fill and overflow, DEPTH=16: write 17 bytes with no pop -> full=1, count=16, overflow=1; clear_overflow -> overflow=0, contents intact.
REQ-037 Full plus simultaneous write and pop: count=16, write 0x77 in the pop-event cycle -> count=16, overflow=0, 0x77 emerges last.
REQ-038 Wrap: push and drain 40 bytes 0x00..0x27 in bursts of 10 -> output sequence identical, no loss.
REQ-039 Reset mid-frame with 3 bytes queued -> count=0, valid=0 next cycle; the subsequent tx_ready pulse leaves count=0.
